// File: rtl/zk_split_pkg.sv
// Shared definitions for the split-transaction loader: frame geometry,
// field boundaries inside the packed transaction vector, and FSM states.
package zk_split_pkg;

    localparam int TX_BITS  = 3704;
    localparam int TX_BYTES = TX_BITS / 8;

    // Field boundaries, MSB first, inside the packed transaction vector
    localparam int NVERSION_MSB      = 3703;
    localparam int NVERSION_LSB      = 3672;
    localparam int HASH_PREVOUTS_MSB = 3671;
    localparam int HASH_PREVOUTS_LSB = 3416;
    localparam int HASH_SEQUENCE_MSB = 3415;
    localparam int HASH_SEQUENCE_LSB = 3160;
    localparam int IN_TXID_MSB       = 3159;
    localparam int IN_TXID_LSB       = 2904;
    localparam int IN_VOUT_MSB       = 2903;
    localparam int IN_VOUT_LSB       = 2872;
    localparam int SCRIPT_MSB        = 2871;
    localparam int SCRIPT_LSB        = 1000;
    localparam int IN_AMOUNT_MSB     = 999;
    localparam int IN_AMOUNT_LSB     = 936;
    localparam int IN_NSEQ_MSB       = 935;
    localparam int IN_NSEQ_LSB       = 904;
    localparam int LOCKTIME_MSB      = 903;
    localparam int LOCKTIME_LSB      = 872;
    localparam int SIGHASH_TYPE_MSB  = 871;
    localparam int SIGHASH_TYPE_LSB  = 840;
    localparam int ENC_OUTPUTS_MSB   = 839;
    localparam int ENC_OUTPUTS_LSB   = 0;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count up on inc until all-ones, never wrap
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/split_tx_loader.sv
// Byte-stream to packed-transaction assembler. Shifts bytes in MSB-first,
// holds one complete frame for the downstream stage, rejects short/long
// frames and keeps saturating good/bad frame counts.
module split_tx_loader #(
    parameter int TX_BYTES = 463,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [TX_BYTES*8-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  tx_zero,
    output logic [CNT_W-1:0]      frames_ok,
    output logic [CNT_W-1:0]      frames_err
);
    import zk_split_pkg::*;

    localparam int TXW = TX_BYTES * 8;
    localparam int CW  = $clog2(TX_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(TX_BYTES - 1);

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          ready_en;   // low only in the reset cycle
    logic          nz;         // running OR of accepted bytes in this frame
    logic          load_xfer;
    logic          at_last;
    logic          short_hit;
    logic          long_hit;
    logic          frame_done;
    logic          drain_done;
    logic          hold_take;

    assign at_last  = (cnt == LAST_IDX);
    assign tx_valid = (state == HOLD);
    assign tx_zero  = tx_valid && !nz;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        load_xfer  = 1'b0;
        short_hit  = 1'b0;
        long_hit   = 1'b0;
        frame_done = 1'b0;
        drain_done = 1'b0;
        hold_take  = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = ready_en;
                load_xfer = in_valid && ready_en;
                if (load_xfer) begin
                    if (at_last && in_last) begin
                        frame_done = 1'b1;
                        state_nxt  = HOLD;
                    end else if (in_last) begin
                        short_hit = 1'b1;
                    end else if (at_last) begin
                        long_hit  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                in_ready = ready_en;
                if (in_valid && ready_en && in_last) begin
                    drain_done = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            HOLD: begin
                if (tx_ready) begin
                    hold_take = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Frame assembly, byte count, zero tracking and error pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            tx_data   <= '0;
            nz        <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            err_short <= short_hit;
            err_long  <= long_hit;
            if (load_xfer) begin
                tx_data <= {tx_data[TXW-9:0], in_data};
                nz      <= nz | (|in_data);
                if (short_hit) begin
                    cnt     <= '0;
                    tx_data <= '0;
                    nz      <= 1'b0;
                end else if (frame_done || long_hit) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (drain_done || hold_take) begin
                tx_data <= '0;
                nz      <= 1'b0;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (hold_take),
        .q     (frames_ok)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (short_hit || long_hit),
        .q     (frames_err)
    );

endmodule

// File: tb/tb_split_tx_loader.sv
// Directed bench for split_tx_loader: frame table plus hand sequences for
// hold, idle tx_ready, mid-frame reset and counter saturation.
module tb_split_tx_loader;

    localparam int NB = 463;
    localparam int W  = NB * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [W-1:0]  tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          err_short;
    logic          err_long;
    logic          tx_zero;
    logic [15:0]   frames_ok;
    logic [15:0]   frames_err;

    // narrow-counter instance used to reach saturation quickly
    logic [7:0]    s_in_data;
    logic          s_in_valid;
    logic          s_in_last;
    logic          s_in_ready;
    logic [W-1:0]  s_tx_data;
    logic          s_tx_valid;
    logic          s_tx_ready;
    logic          s_err_short;
    logic          s_err_long;
    logic          s_tx_zero;
    logic [1:0]    s_frames_ok;
    logic [1:0]    s_frames_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    split_tx_loader #(.TX_BYTES(NB), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .err_short(err_short),
        .err_long(err_long), .tx_zero(tx_zero), .frames_ok(frames_ok),
        .frames_err(frames_err)
    );

    split_tx_loader #(.TX_BYTES(NB), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_last(s_in_last), .in_ready(s_in_ready), .tx_data(s_tx_data),
        .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .err_short(s_err_short),
        .err_long(s_err_long), .tx_zero(s_tx_zero), .frames_ok(s_frames_ok),
        .frames_err(s_frames_err)
    );

    typedef struct {
        int mode;      // byte pattern selector
        int len;       // bytes sent, in_last on the final one
        bit gaps;      // random in_valid gaps
        int kind;      // 0 good, 1 short, 2 long
        bit exp_zero;
        int exp_ok;
        int exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            int idx;
            idx = 0;
            for (int b = NB - 1; b >= 0; b--)
                if (act[W-1-8*b -: 8] !== exp[W-1-8*b -: 8]) idx = b;
            n_fail++;
            $display("FAIL %s: byte %0d got %02h expected %02h", name, idx,
                     act[W-1-8*idx -: 8], exp[W-1-8*idx -: 8]);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'h00;
            2:       return (i == 200) ? 8'h01 : 8'h00;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    function automatic logic [W-1:0] model(input int mode);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[W-1-8*i -: 8] = pat(mode, i);
        return v;
    endfunction

    // Sends len bytes; records where error pulses and tx_valid were first seen.
    task automatic send_frame(input int mode, input int len, input bit gaps, input bit with_last,
                              output int short_n, output int short_at,
                              output int long_n, output int long_at, output int valid_at);
        int guard;
        short_n = 0; long_n = 0; short_at = -1; long_at = -1; valid_at = -1;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 9) < 3) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_data  = pat(mode, i);
            in_last  = with_last && (i == len - 1);
            in_valid = 1'b1;
            guard = 0;
            while (in_ready !== 1'b1 && guard < 1000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 1000) begin
                n_tests++;
                n_fail++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at byte %0d", i);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (err_short === 1'b1) begin short_n++; if (short_at < 0) short_at = i; end
            if (err_long === 1'b1)  begin long_n++;  if (long_at < 0)  long_at = i;  end
            if (tx_valid === 1'b1 && valid_at < 0) valid_at = i;
        end
    endtask

    task automatic consume();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] snap;
        int sn, sa, ln, la, va;

        vecs[0] = '{mode:0, len:101, gaps:0, kind:1, exp_zero:0, exp_ok:1, exp_err:1};
        vecs[1] = '{mode:3, len:NB,  gaps:0, kind:0, exp_zero:0, exp_ok:2, exp_err:1};
        vecs[2] = '{mode:3, len:470, gaps:0, kind:2, exp_zero:0, exp_ok:2, exp_err:2};
        vecs[3] = '{mode:0, len:NB,  gaps:0, kind:0, exp_zero:0, exp_ok:3, exp_err:2};
        vecs[4] = '{mode:1, len:NB,  gaps:1, kind:0, exp_zero:1, exp_ok:4, exp_err:2};
        vecs[5] = '{mode:2, len:NB,  gaps:1, kind:0, exp_zero:0, exp_ok:5, exp_err:2};

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b0;
        s_in_data = '0; s_in_valid = 1'b0; s_in_last = 1'b0; s_tx_ready = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_long", err_long, 0);
        chk("rst_tx_zero", tx_zero, 0);
        chk("rst_frames_ok", frames_ok, 0);
        chk("rst_frames_err", frames_err, 0);
        chk_data("rst_tx_data", tx_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_tx_valid", tx_valid, 0);

        // nominal frame held for 5 cycles, with stray bytes offered in HOLD
        send_frame(0, NB, 0, 1, sn, sa, ln, la, va);
        chk("nom_valid_at", va, NB - 1);
        snap = tx_data;
        in_data = 8'hFF; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("nom_hold_valid", tx_valid, 1);
            chk("nom_hold_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk_data("nom_hold_stable", tx_data, snap);
        chk("nom_byte0", tx_data[3703:3696], 8'h00);
        chk("nom_byte1", tx_data[3695:3688], 8'h01);
        chk("nom_byte462", tx_data[7:0], 8'hCE);
        chk("nom_zero", tx_zero, 0);
        consume();
        chk("nom_taken_valid", tx_valid, 0);
        chk("nom_frames_ok", frames_ok, 1);

        // table-driven frames
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].mode, vecs[v].len, vecs[v].gaps, 1, sn, sa, ln, la, va);
            case (vecs[v].kind)
                0: begin
                    chk($sformatf("v%0d_valid_at", v), va, vecs[v].len - 1);
                    chk($sformatf("v%0d_no_err", v), sn + ln, 0);
                    chk_data($sformatf("v%0d_data", v), tx_data, model(vecs[v].mode));
                    chk($sformatf("v%0d_zero", v), tx_zero, vecs[v].exp_zero);
                    chk($sformatf("v%0d_in_ready", v), in_ready, 0);
                    consume();
                    chk($sformatf("v%0d_taken", v), tx_valid, 0);
                end
                1: begin
                    chk($sformatf("v%0d_short_n", v), sn, 1);
                    chk($sformatf("v%0d_short_at", v), sa, vecs[v].len - 1);
                    chk($sformatf("v%0d_long_n", v), ln, 0);
                    chk($sformatf("v%0d_no_valid", v), va, -1);
                    @(posedge clk); #1;
                    chk($sformatf("v%0d_short_pulse_end", v), err_short, 0);
                    chk($sformatf("v%0d_in_ready", v), in_ready, 1);
                end
                default: begin
                    chk($sformatf("v%0d_long_n", v), ln, 1);
                    chk($sformatf("v%0d_long_at", v), la, NB - 1);
                    chk($sformatf("v%0d_short_n", v), sn, 0);
                    chk($sformatf("v%0d_no_valid", v), va, -1);
                    chk($sformatf("v%0d_tx_valid", v), tx_valid, 0);
                end
            endcase
            chk($sformatf("v%0d_frames_ok", v), frames_ok, vecs[v].exp_ok);
            chk($sformatf("v%0d_frames_err", v), frames_err, vecs[v].exp_err);
        end

        // tx_ready while nothing is held
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("idle_ready_valid", tx_valid, 0);
        chk("idle_ready_ok", frames_ok, 5);

        // reset in the middle of a frame, then a complete frame
        send_frame(3, 300, 0, 0, sn, sa, ln, la, va);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_err_short", err_short, 0);
        chk("midrst_err_long", err_long, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(0, NB, 0, 1, sn, sa, ln, la, va);
        chk("midrst_valid_at", va, NB - 1);
        chk_data("midrst_data", tx_data, model(0));
        consume();
        chk("midrst_frames_ok", frames_ok, 1);
        chk("midrst_frames_err", frames_err, 0);

        // saturation: one-byte short frames into a 2-bit error counter
        s_in_data = 8'h55; s_in_valid = 1'b1; s_in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_err_at3", s_frames_err, 2'b11);
        chk("sat_short_pulse", s_err_short, 1);
        repeat (2) @(posedge clk);
        #1;
        s_in_valid = 1'b0; s_in_last = 1'b0;
        chk("sat_err_hold", s_frames_err, 2'b11);
        chk("sat_ok", s_frames_ok, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
